// File: rtl/wb_pkg.sv
// Shared widths and the queue entry layout for the write-back queue.
package wb_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int POS_W  = 4;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [POS_W-1:0]  pos;
   } wb_entry_t;

endpackage

// File: rtl/wb_queue_if.sv
// Upstream write-back handshake: the producer drives valid/payload, the queue drives ready.
interface wb_queue_if;
   import wb_pkg::*;

   logic              wb_valid_i;
   logic              wb_ready_o;
   logic [ADDR_W-1:0] wb_addr_i;
   logic [DATA_W-1:0] wb_data_i;
   logic [POS_W-1:0]  wb_pos_i;

   modport master (
      output wb_valid_i, wb_addr_i, wb_data_i, wb_pos_i,
      input  wb_ready_o
   );

   modport slave (
      input  wb_valid_i, wb_addr_i, wb_data_i, wb_pos_i,
      output wb_ready_o
   );

endinterface

// File: rtl/wb_fifo.sv
// Circular entry storage with head/tail pointers and occupancy; all slots are
// exposed so the parent can search pending writes.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     reset,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  wb_entry_t                push_entry_i,
   output wb_entry_t                head_entry_o,
   output logic [$clog2(DEPTH)-1:0] head_ptr_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output wb_entry_t                entries_o [DEPTH]
);

   localparam int PTR_W = $clog2(DEPTH);

   wb_entry_t        mem_reg [DEPTH];
   logic [PTR_W-1:0] head_reg;
   logic [PTR_W-1:0] tail_reg;
   logic [PTR_W:0]   count_reg;

   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_reg[tail_reg] <= push_entry_i;
      end
   end

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk_i) begin
      if (reset || flush_i) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         if (push_i) begin
            tail_reg <= tail_reg + PTR_W'(1);
         end
         if (pop_i) begin
            head_reg <= head_reg + PTR_W'(1);
         end
         case ({push_i, pop_i})
            2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
            2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign head_entry_o = mem_reg[head_reg];
   assign head_ptr_o   = head_reg;
   assign count_o      = count_reg;
   assign full_o       = (count_reg == (PTR_W+1)'(DEPTH));
   assign entries_o    = mem_reg;

endmodule

// File: rtl/wb_queue.sv
// Write-back queue: FIFO of pending register writes, registered write port,
// saturating fault counter. WB_QUEUE_FWD_EN enables RS/RT forwarding lookup.
module wb_queue
   import wb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                   clk_i,
   input  logic                   reset,
   wb_queue_if.slave              wb,
   input  logic                   hold_i,
   input  logic                   flush_i,
   output logic                   RegWrite_o,
   output logic [ADDR_W-1:0]      RDaddr_o,
   output logic [DATA_W-1:0]      RDdata_o,
   output logic [POS_W-1:0]       is_pos_o,
   input  logic [ADDR_W-1:0]      RSaddr_i,
   input  logic [ADDR_W-1:0]      RTaddr_i,
   output logic                   RS_hit_o,
   output logic                   RT_hit_o,
   output logic [DATA_W-1:0]      RS_fwd_o,
   output logic [DATA_W-1:0]      RT_fwd_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic [CNT_W-1:0]       fault_cnt_o
);

   wb_entry_t                push_entry;
   wb_entry_t                head_entry;
   wb_entry_t                entries [DEPTH];
   logic [$clog2(DEPTH)-1:0] head_ptr;
   logic [$clog2(DEPTH):0]   count;
   logic                     full;
   logic                     push;
   logic                     pop;

   logic                     regwrite_reg;
   logic [ADDR_W-1:0]        rdaddr_reg;
   logic [DATA_W-1:0]        rddata_reg;
   logic [POS_W-1:0]         pos_reg;
   logic [CNT_W-1:0]         fault_reg;

   genvar gi;

   // Ready depends only on occupancy, so a same-cycle pop never frees a slot.
   assign wb.wb_ready_o = !full;
   assign push          = wb.wb_valid_i && !full && !flush_i;
   assign pop           = (count != '0) && !hold_i && !flush_i;

   assign push_entry.addr = wb.wb_addr_i;
   assign push_entry.data = wb.wb_data_i;
   assign push_entry.pos  = wb.wb_pos_i;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i        (clk_i),
      .reset        (reset),
      .flush_i      (flush_i),
      .push_i       (push),
      .pop_i        (pop),
      .push_entry_i (push_entry),
      .head_entry_o (head_entry),
      .head_ptr_o   (head_ptr),
      .count_o      (count),
      .full_o       (full),
      .entries_o    (entries)
   );

   always_ff @(posedge clk_i) begin
      if (reset) begin
         regwrite_reg <= 1'b0;
         rdaddr_reg   <= '0;
         rddata_reg   <= '0;
         pos_reg      <= '0;
      end else if (pop) begin
         regwrite_reg <= 1'b1;
         rdaddr_reg   <= head_entry.addr;
         rddata_reg   <= head_entry.data;
         pos_reg      <= head_entry.pos;
      end else begin
         regwrite_reg <= 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset) begin
         fault_reg <= '0;
      end else if (pop && (head_entry.pos != '0) && (fault_reg != {CNT_W{1'b1}})) begin
         fault_reg <= fault_reg + CNT_W'(1);
      end
   end

   assign RegWrite_o  = regwrite_reg;
   assign RDaddr_o    = rdaddr_reg;
   assign RDdata_o    = rddata_reg;
   assign is_pos_o    = pos_reg;
   assign count_o     = count;
   assign fault_cnt_o = fault_reg;

`ifdef WB_QUEUE_FWD_EN
   localparam int PTR_W = $clog2(DEPTH);

   logic [DEPTH-1:0]  rs_match;
   logic [DEPTH-1:0]  rt_match;
   logic [DATA_W-1:0] slot_data [DEPTH];

   // Slot gi is the gi-th oldest pending entry; a higher gi is newer.
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_slot
         logic [PTR_W-1:0] idx;
         logic             live;
         assign idx           = head_ptr + PTR_W'(gi);
         assign live          = ((PTR_W+1)'(gi) < count);
         assign slot_data[gi] = entries[idx].data;
         assign rs_match[gi]  = live && (entries[idx].addr == RSaddr_i);
         assign rt_match[gi]  = live && (entries[idx].addr == RTaddr_i);
      end
   endgenerate

   // The output stage is older than anything still queued, so it is the fallback.
   always_comb begin
      RS_hit_o = regwrite_reg && (rdaddr_reg == RSaddr_i);
      RT_hit_o = regwrite_reg && (rdaddr_reg == RTaddr_i);
      RS_fwd_o = RS_hit_o ? rddata_reg : '0;
      RT_fwd_o = RT_hit_o ? rddata_reg : '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (rs_match[i]) begin
            RS_hit_o = 1'b1;
            RS_fwd_o = slot_data[i];
         end
         if (rt_match[i]) begin
            RT_hit_o = 1'b1;
            RT_fwd_o = slot_data[i];
         end
      end
   end
`else
   logic [DEPTH-1:0] fwd_unused_bits;
   logic             fwd_unused;

   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_sink
         assign fwd_unused_bits[gi] = ^entries[gi];
      end
   endgenerate

   assign fwd_unused = ^{fwd_unused_bits, head_ptr, RSaddr_i, RTaddr_i};
   assign RS_hit_o   = 1'b0;
   assign RT_hit_o   = 1'b0;
   assign RS_fwd_o   = '0;
   assign RT_fwd_o   = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: scenario tasks plus a scoreboard that
// checks every register-file write against the pushed order.
module tb_wb_queue;
   import wb_pkg::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic              hold;
   logic              flush;
   logic              RegWrite;
   logic [ADDR_W-1:0] RDaddr;
   logic [DATA_W-1:0] RDdata;
   logic [POS_W-1:0]  is_pos;
   logic [ADDR_W-1:0] rs_addr;
   logic [ADDR_W-1:0] rt_addr;
   logic              rs_hit;
   logic              rt_hit;
   logic [DATA_W-1:0] rs_fwd;
   logic [DATA_W-1:0] rt_fwd;
   logic [2:0]        count;
   logic [CNT_W-1:0]  fault_cnt;

   wb_queue_if wb ();

   wb_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk_i       (clk),
      .reset       (reset),
      .wb          (wb),
      .hold_i      (hold),
      .flush_i     (flush),
      .RegWrite_o  (RegWrite),
      .RDaddr_o    (RDaddr),
      .RDdata_o    (RDdata),
      .is_pos_o    (is_pos),
      .RSaddr_i    (rs_addr),
      .RTaddr_i    (rt_addr),
      .RS_hit_o    (rs_hit),
      .RT_hit_o    (rt_hit),
      .RS_fwd_o    (rs_fwd),
      .RT_fwd_o    (rt_fwd),
      .count_o     (count),
      .fault_cnt_o (fault_cnt)
   );

   always #5 clk = ~clk;

   wb_entry_t sb[$];
   int        tests_run    = 0;
   int        tests_failed = 0;

`ifdef WB_QUEUE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wb.wb_valid_i = 1'b0;
   endtask

   // Inputs change 1 time unit after the edge, so ready seen here is what the next edge sees.
   task automatic drive(input logic [4:0] a, input logic [31:0] d, input logic [3:0] p);
      wb_entry_t e;
      wb.wb_valid_i = 1'b1;
      wb.wb_addr_i  = a;
      wb.wb_data_i  = d;
      wb.wb_pos_i   = p;
      e.addr = a;
      e.data = d;
      e.pos  = p;
      if (wb.wb_ready_o && !flush && !reset) sb.push_back(e);
   endtask

   always @(posedge clk) begin
      wb_entry_t exp_e;
      #1;
      if (RegWrite === 1'b1) begin
         tests_run++;
         $display("[TB] write rd=%0d data=%h pos=%h", RDaddr, RDdata, is_pos);
         if (sb.size() == 0) begin
            tests_failed++;
            $display("FAIL sb_unexpected: write rd=%0d data=%h with nothing pending", RDaddr, RDdata);
         end else begin
            exp_e = sb.pop_front();
            if ({RDaddr, RDdata, is_pos} !== exp_e) begin
               tests_failed++;
               $display("FAIL sb_order: got rd=%0d data=%h pos=%h want rd=%0d data=%h pos=%h",
                        RDaddr, RDdata, is_pos, exp_e.addr, exp_e.data, exp_e.pos);
            end
         end
      end
   end

   task automatic test_reset();
      reset = 1'b1; hold = 1'b0; flush = 1'b0; rs_addr = '0; rt_addr = '0;
      idle();
      wb.wb_addr_i = '0; wb.wb_data_i = '0; wb.wb_pos_i = '0;
      step(); step();
      tests_run++;
      if ({count, wb.wb_ready_o, RegWrite, RDaddr, RDdata, is_pos, fault_cnt} !==
          {3'd0, 1'b1, 1'b0, 5'd0, 32'd0, 4'd0, 2'd0}) begin
         tests_failed++;
         $display("FAIL reset_state: count=%0d ready=%b we=%b rd=%0d data=%h pos=%h fault=%0d want 0/1/0/0/0/0/0",
                  count, wb.wb_ready_o, RegWrite, RDaddr, RDdata, is_pos, fault_cnt);
      end
      reset = 1'b0;
   endtask

   task automatic test_latency();
      drive(5'd3, 32'h11, 4'h0); step();
      tests_run++;
      if (count !== 3'd1 || RegWrite !== 1'b0) begin
         tests_failed++;
         $display("FAIL lat_edge_e: count=%0d we=%b want 1/0", count, RegWrite);
      end
      idle(); step();
      tests_run++;
      if (RegWrite !== 1'b1 || RDaddr !== 5'd3 || RDdata !== 32'h11 || count !== 3'd0) begin
         tests_failed++;
         $display("FAIL lat_edge_e1: we=%b rd=%0d data=%h count=%0d want 1/3/11/0", RegWrite, RDaddr, RDdata, count);
      end
      step();
      tests_run++;
      if (RegWrite !== 1'b0 || RDaddr !== 5'd3 || RDdata !== 32'h11) begin
         tests_failed++;
         $display("FAIL lat_hold_out: we=%b rd=%0d data=%h want 0/3/11", RegWrite, RDaddr, RDdata);
      end
   endtask

   task automatic test_hold_full();
      hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(5'(10 + i), 32'h100 + i, 4'h0); step();
      end
      tests_run++;
      if (count !== 3'd4 || wb.wb_ready_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL full_state: count=%0d ready=%b want 4/0", count, wb.wb_ready_o);
      end
      drive(5'd20, 32'hDEAD, 4'h0); step();
      tests_run++;
      if (count !== 3'd4) begin
         tests_failed++;
         $display("FAIL full_reject: count=%0d want 4", count);
      end
      idle(); hold = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         tests_run++;
         if (RegWrite !== 1'b1 || count !== 3'(3 - i)) begin
            tests_failed++;
            $display("FAIL drain_%0d: we=%b count=%0d want 1/%0d", i, RegWrite, count, 3 - i);
         end
      end
      step();
      tests_run++;
      if (RegWrite !== 1'b0) begin
         tests_failed++;
         $display("FAIL drain_done: we=%b want 0", RegWrite);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++) begin
         drive(5'(i + 1), 32'h2000 + i, 4'h0); step();
         tests_run++;
         if (count !== 3'd1) begin
            tests_failed++;
            $display("FAIL b2b_count_%0d: count=%0d want 1", i, count);
         end
      end
      idle(); step();
      tests_run++;
      if (count !== 3'd0) begin
         tests_failed++;
         $display("FAIL b2b_empty: count=%0d want 0", count);
      end
      step();
   endtask

   task automatic test_no_pushthrough();
      hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(5'(24 + i), 32'h3000 + i, 4'h0); step();
      end
      hold = 1'b0;
      drive(5'd30, 32'h30FF, 4'h0); step();
      tests_run++;
      if (count !== 3'd3) begin
         tests_failed++;
         $display("FAIL no_pushthrough: count=%0d want 3", count);
      end
      drive(5'd31, 32'h3100, 4'h0); step();
      tests_run++;
      if (count !== 3'd3) begin
         tests_failed++;
         $display("FAIL push_pop_same: count=%0d want 3", count);
      end
      idle();
      for (int i = 0; i < 4; i++) step();
      tests_run++;
      if (count !== 3'd0 || RegWrite !== 1'b0) begin
         tests_failed++;
         $display("FAIL npt_drain: count=%0d we=%b want 0/0", count, RegWrite);
      end
   endtask

   task automatic test_forward();
      hold = 1'b1;
      drive(5'd9, 32'h99, 4'h0); step();
      drive(5'd5, 32'hA, 4'h0);  step();
      drive(5'd5, 32'hB, 4'h0);  step();
      drive(5'd0, 32'h55, 4'h0); step();
      idle();
      rs_addr = 5'd5; rt_addr = 5'd0; #1;
      tests_run++;
      if (rs_hit !== FWD || rs_fwd !== (FWD ? 32'hB : 32'h0) ||
          rt_hit !== FWD || rt_fwd !== (FWD ? 32'h55 : 32'h0)) begin
         tests_failed++;
         $display("FAIL fwd_newest: rs=%b/%h rt=%b/%h fwd_en=%b", rs_hit, rs_fwd, rt_hit, rt_fwd, FWD);
      end
      rs_addr = 5'd12; #1;
      tests_run++;
      if (rs_hit !== 1'b0 || rs_fwd !== 32'h0) begin
         tests_failed++;
         $display("FAIL fwd_miss: rs=%b/%h want 0/0", rs_hit, rs_fwd);
      end
      hold = 1'b0; step(); hold = 1'b1;
      rs_addr = 5'd9; rt_addr = 5'd5; #1;
      tests_run++;
      if (RegWrite !== 1'b1 || rs_hit !== FWD || rs_fwd !== (FWD ? 32'h99 : 32'h0) ||
          rt_hit !== FWD || rt_fwd !== (FWD ? 32'hB : 32'h0)) begin
         tests_failed++;
         $display("FAIL fwd_outstage: we=%b rs=%b/%h rt=%b/%h fwd_en=%b", RegWrite, rs_hit, rs_fwd, rt_hit, rt_fwd, FWD);
      end
      step();
      tests_run++;
      if (rs_hit !== 1'b0 || rs_fwd !== 32'h0) begin
         tests_failed++;
         $display("FAIL fwd_outstage_idle: rs=%b/%h want 0/0", rs_hit, rs_fwd);
      end
      hold = 1'b0;
      for (int i = 0; i < 4; i++) step();
      rs_addr = '0; rt_addr = '0;
   endtask

   task automatic test_flush();
      logic [CNT_W-1:0] f0;
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(5'(12 + i), 32'h400 + i, 4'h1); step();
      end
      f0 = fault_cnt;
      tests_run++;
      if (count !== 3'd3) begin
         tests_failed++;
         $display("FAIL flush_fill: count=%0d want 3", count);
      end
      flush = 1'b1; hold = 1'b0;
      drive(5'd7, 32'h77, 4'h1); step();
      sb.delete();
      tests_run++;
      if (count !== 3'd0 || RegWrite !== 1'b0 || fault_cnt !== f0) begin
         tests_failed++;
         $display("FAIL flush_edge: count=%0d we=%b fault=%0d want 0/0/%0d", count, RegWrite, fault_cnt, f0);
      end
      flush = 1'b0; idle(); step();
      tests_run++;
      if (count !== 3'd0 || RegWrite !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_dropped: count=%0d we=%b want 0/0", count, RegWrite);
      end
   endtask

   task automatic test_fault_sat();
      reset = 1'b1; step(); reset = 1'b0; sb.delete();
      drive(5'd1, 32'h1, 4'h0); step(); idle(); step(); step();
      tests_run++;
      if (fault_cnt !== 2'd0) begin
         tests_failed++;
         $display("FAIL fault_zero_tag: fault=%0d want 0", fault_cnt);
      end
      for (int i = 0; i < 5; i++) begin
         drive(5'(2 + i), 32'h40 + i, 4'h2); step();
         if (i == 2) begin
            tests_run++;
            if (fault_cnt !== 2'd2) begin
               tests_failed++;
               $display("FAIL fault_mid: fault=%0d want 2", fault_cnt);
            end
         end
      end
      idle();
      for (int i = 0; i < 3; i++) step();
      tests_run++;
      if (fault_cnt !== 2'd3) begin
         tests_failed++;
         $display("FAIL fault_sat: fault=%0d want 3", fault_cnt);
      end
   endtask

   task automatic test_reset_mid();
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(5'(17 + i), 32'h500 + i, 4'h3); step();
      end
      idle(); hold = 1'b0; step();
      tests_run++;
      if (RegWrite !== 1'b1 || count !== 3'd2) begin
         tests_failed++;
         $display("FAIL rmid_pre: we=%b count=%0d want 1/2", RegWrite, count);
      end
      reset = 1'b1; flush = 1'b1;
      drive(5'd8, 32'h88, 4'h1); step();
      sb.delete();
      tests_run++;
      if ({count, wb.wb_ready_o, RegWrite, RDaddr, RDdata, is_pos, fault_cnt} !==
          {3'd0, 1'b1, 1'b0, 5'd0, 32'd0, 4'd0, 2'd0}) begin
         tests_failed++;
         $display("FAIL rmid_state: count=%0d ready=%b we=%b rd=%0d data=%h pos=%h fault=%0d want 0/1/0/0/0/0/0",
                  count, wb.wb_ready_o, RegWrite, RDaddr, RDdata, is_pos, fault_cnt);
      end
      reset = 1'b0; flush = 1'b0; idle(); step(); step();
      tests_run++;
      if (count !== 3'd0 || RegWrite !== 1'b0) begin
         tests_failed++;
         $display("FAIL rmid_discard: count=%0d we=%b want 0/0", count, RegWrite);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_hold_full();
      test_back_to_back();
      test_no_pushthrough();
      test_forward();
      test_flush();
      test_fault_sat();
      test_reset_mid();
      tests_run++;
      if (sb.size() != 0) begin
         tests_failed++;
         $display("FAIL sb_leftover: %0d pending writes never retired, want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
